// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter, one-stage write pipeline and one-hot read decode for the register file.
// Optional same-cycle write forwarding is built when REGFILE_ARB_BYPASS_EN is defined.
module regfile_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic [AW-1:0]        rd_addr1,
  input  logic [AW-1:0]        rd_addr2,
  output logic [NREG-1:0]      wr_en,
  output logic [DW-1:0]        wr_data,
  output logic [NREG-1:0]      out_en1,
  output logic [NREG-1:0]      out_en2,
  output logic                 rd_zero1,
  output logic                 rd_zero2,
  output logic                 fwd1,
  output logic                 fwd2,
  output logic [DW-1:0]        fwd_data,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic [AW-1:0] req_addr_arr [NREQ];
  logic [DW-1:0] req_data_arr [NREQ];

  logic          grant_valid;
  logic [PW-1:0] grant_idx;
  logic [PW:0]   scan_idx;
  logic [PW:0]   next_ptr;

  genvar gi;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_addr_arr[gi] = req_addr[gi*AW +: AW];
      assign req_data_arr[gi] = req_data[gi*DW +: DW];
      assign req_ready[gi]    = !clr && grant_valid && (grant_idx == PW'(gi));
    end
  endgenerate

  // Scan requesters starting at rr_ptr, wrapping modulo NREQ; first valid wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan_idx >= (PW+1)'(NREQ)) begin
        scan_idx = scan_idx - (PW+1)'(NREQ);
      end
      if (!grant_valid && req_valid[scan_idx[PW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    pend_d   = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    next_ptr = {1'b0, grant_idx} + (PW+1)'(1);
    if (next_ptr >= (PW+1)'(NREQ)) begin
      next_ptr = '0;
    end
    if (grant_valid) begin
      rr_ptr_d = next_ptr[PW-1:0];
      addr_d   = req_addr_arr[grant_idx];
      data_d   = req_data_arr[grant_idx];
      // Writes to register 0 are accepted but never reach the cells.
      pend_d   = (req_addr_arr[grant_idx] != '0);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rr_ptr_q <= '0;
      pend_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      pend_q   <= pend_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      assign wr_en[gi] = pend_q && (addr_q == AW'(gi));
      if (gi == 0) begin : g_zero
        assign out_en1[gi] = 1'b0;
        assign out_en2[gi] = 1'b0;
      end else begin : g_nz
        assign out_en1[gi] = (rd_addr1 == AW'(gi));
        assign out_en2[gi] = (rd_addr2 == AW'(gi));
      end
    end
  endgenerate

  assign wr_data  = data_q;
  assign busy     = pend_q;
  assign rd_zero1 = (rd_addr1 == '0);
  assign rd_zero2 = (rd_addr2 == '0);

`ifdef REGFILE_ARB_BYPASS_EN
  assign fwd1     = pend_q && (rd_addr1 == addr_q);
  assign fwd2     = pend_q && (rd_addr2 == addr_q);
  assign fwd_data = data_q;
`else
  assign fwd1     = 1'b0;
  assign fwd2     = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed plus randomized bench for regfile_wr_arbiter against a cycle-level behavioural model.
module tb_regfile_wr_arbiter;
  localparam int NREQ = 4;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 clr;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [AW-1:0]        rd_addr1, rd_addr2;
  logic [NREG-1:0]      wr_en;
  logic [DW-1:0]        wr_data;
  logic [NREG-1:0]      out_en1, out_en2;
  logic                 rd_zero1, rd_zero2, fwd1, fwd2, busy;
  logic [DW-1:0]        fwd_data;

  regfile_wr_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_en(wr_en),
    .wr_data(wr_data), .out_en1(out_en1), .out_en2(out_en2), .rd_zero1(rd_zero1),
    .rd_zero2(rd_zero2), .fwd1(fwd1), .fwd2(fwd2), .fwd_data(fwd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Requester-side stimulus state
  bit            v [NREQ];
  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] d [NREQ];

  // Behavioural model state
  int            m_rr;
  bit            m_pend;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = v[i];
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
    #1;
  endtask

  function automatic int model_grant();
    if (clr) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_pend = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_edge();
    if (clr) begin
      model_reset();
      m_gnt = -1;
    end else begin
      m_gnt = model_grant();
      if (m_gnt >= 0) begin
        m_rr   = (m_gnt + 1) % NREQ;
        m_addr = a[m_gnt];
        m_data = d[m_gnt];
        m_pend = (a[m_gnt] != 0);
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    int g;
    logic [63:0] e_wr, e_o1, e_o2;
    bit e_f1, e_f2;
    logic [DW-1:0] e_fd;
    g    = model_grant();
    e_wr = m_pend ? (64'd1 << m_addr) : 64'd0;
    e_o1 = (rd_addr1 == 0) ? 64'd0 : (64'd1 << rd_addr1);
    e_o2 = (rd_addr2 == 0) ? 64'd0 : (64'd1 << rd_addr2);
`ifdef REGFILE_ARB_BYPASS_EN
    e_f1 = m_pend && (rd_addr1 == m_addr);
    e_f2 = m_pend && (rd_addr2 == m_addr);
    e_fd = m_data;
`else
    e_f1 = 1'b0;
    e_f2 = 1'b0;
    e_fd = '0;
`endif
    chk({tag, ".req_ready"}, req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    chk({tag, ".wr_en"},     wr_en,    e_wr);
    chk({tag, ".wr_data"},   wr_data,  m_data);
    chk({tag, ".busy"},      busy,     m_pend);
    chk({tag, ".out_en1"},   out_en1,  e_o1);
    chk({tag, ".out_en2"},   out_en2,  e_o2);
    chk({tag, ".rd_zero1"},  rd_zero1, rd_addr1 == 0);
    chk({tag, ".rd_zero2"},  rd_zero2, rd_addr2 == 0);
    chk({tag, ".fwd1"},      fwd1,     e_f1);
    chk({tag, ".fwd2"},      fwd2,     e_f2);
    chk({tag, ".fwd_data"},  fwd_data, e_fd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1;
    rd_addr1 = '0;
    rd_addr2 = '0;
    m_gnt = -1;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0; a[i] = '0; d[i] = '0;
    end
    model_reset();

    // Reset state
    @(negedge clk);
    apply();
    check_all("reset");
    tick();
    clr = 1'b0;

    // Single write: req1 -> r7
    v[1] = 1'b1; a[1] = 5'd7; d[1] = 32'hDEADBEEF;
    apply();
    chk("single.ready", req_ready, 4'b0010);
    tick();
    v[1] = 1'b0;
    apply();
    chk("single.wr_en", wr_en, 32'h0000_0080);
    chk("single.wr_data", wr_data, 32'hDEADBEEF);
    check_all("single.pend");
    tick();
    apply();
    chk("single.idle", wr_en, 32'h0);

    // Reset asserted mid-cycle with a write pending
    v[2] = 1'b1; a[2] = 5'd9; d[2] = 32'hCAFE0009;
    apply();
    tick();
    v[2] = 1'b0; v[3] = 1'b1; a[3] = 5'd3; d[3] = 32'h3;
    apply();
    chk("clr.pre_busy", busy, 1'b1);
    chk("clr.pre_ready", req_ready, 4'b1000);
    #2 clr = 1'b1;
    #1;
    model_reset();
    chk("clr.wr_en", wr_en, 32'h0);
    chk("clr.busy", busy, 1'b0);
    chk("clr.ready", req_ready, 4'b0000);
    check_all("clr");
    tick();
    clr = 1'b0; v[3] = 1'b0; v[0] = 1'b1; a[0] = 5'd4; d[0] = 32'h44;
    apply();
    chk("clr.after_ready", req_ready, 4'b0001);
    check_all("clr.after");
    tick();
    v[0] = 1'b0;

    // Round-robin from a fresh reset with all requesters valid
    clr = 1'b1;
    apply();
    model_reset();
    tick();
    clr = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b1; a[i] = AW'($urandom_range(1, NREG-1)); d[i] = $urandom;
    end
    for (int k = 0; k < 8; k++) begin
      apply();
      chk($sformatf("rr.grant%0d", k), req_ready, 64'd1 << (k % NREQ));
      check_all("rr");
      tick();
      a[m_gnt] = AW'($urandom_range(1, NREG-1));
      d[m_gnt] = $urandom;
    end
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    v[2] = 1'b1;
    apply();
    chk("rr.req2_alone", req_ready, 4'b0100);
    tick();
    v[2] = 1'b0;

    // Write to register 0 is accepted and dropped
    v[0] = 1'b1; a[0] = 5'd0; d[0] = 32'h55;
    apply();
    chk("r0.ready", req_ready, 4'b0001);
    tick();
    v[0] = 1'b0; rd_addr1 = 5'd0;
    apply();
    chk("r0.wr_en", wr_en, 32'h0);
    chk("r0.busy", busy, 1'b0);
    chk("r0.out_en1", out_en1, 32'h0);
    chk("r0.rd_zero1", rd_zero1, 1'b1);

    // Read decode extremes
    rd_addr1 = 5'd31; rd_addr2 = 5'd1;
    apply();
    chk("dec.out_en1", out_en1, 32'h8000_0000);
    chk("dec.out_en2", out_en2, 32'h0000_0002);
    chk("dec.rd_zero1", rd_zero1, 1'b0);
    chk("dec.rd_zero2", rd_zero2, 1'b0);

    // Forwarding window
    v[1] = 1'b1; a[1] = 5'd5; d[1] = 32'h1234;
    apply();
    tick();
    v[1] = 1'b0; rd_addr1 = 5'd6; rd_addr2 = 5'd5;
    apply();
`ifdef REGFILE_ARB_BYPASS_EN
    chk("byp.fwd2", fwd2, 1'b1);
    chk("byp.fwd_data", fwd_data, 32'h1234);
    chk("byp.fwd1", fwd1, 1'b0);
`else
    chk("byp.fwd2", fwd2, 1'b0);
    chk("byp.fwd_data", fwd_data, 32'h0);
`endif
    check_all("byp");
    tick();

    // Randomized traffic honouring hold-until-ready, with occasional withdrawals and resets
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (v[i] && m_gnt == i) begin
          v[i] = ($urandom_range(0, 1) == 1);
          a[i] = AW'($urandom_range(0, NREG-1));
          d[i] = $urandom;
        end else if (v[i]) begin
          if ($urandom_range(0, 9) == 0) v[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          a[i] = AW'($urandom_range(0, NREG-1));
          d[i] = $urandom;
        end
      end
      rd_addr1 = AW'($urandom_range(0, NREG-1));
      rd_addr2 = ($urandom_range(0, 2) == 0) ? m_addr : AW'($urandom_range(0, NREG-1));
      if ($urandom_range(0, 49) == 0) begin
        clr = 1'b1;
        apply();
        model_reset();
        check_all("rand.clr");
        tick();
        clr = 1'b0;
      end else begin
        apply();
        check_all("rand");
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter and port-enable sequencer for the register file built from single-bit register cells with per-cell `in_en`, `out_en1`, `out_en2` and tri-state read outputs. It shares the file's single write port among `NREQ` requesters with round-robin valid/ready arbitration and registers the granted write into a one-stage write pipeline. It decodes the two read addresses into one-hot tri-state enables and hard-wires register 0 to zero. It sits between the execute/writeback requesters and the register-file array.

## Interface
Parameters:
- `NREQ`, 4: number of write requesters, 2..8.
- `NREG`, 32: number of registers; equals 2^`AW`.
- `AW`, 5: register address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `clr`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  NREQ  requester i has a pending write.
- `req_addr`  in  NREQ*AW  requester i address in bits [i*AW +: AW].
- `req_data`  in  NREQ*DW  requester i data in bits [i*DW +: DW].
- `req_ready`  out  NREQ  one-hot grant; transfer occurs when valid&ready.
- `rd_addr1`, `rd_addr2`  in  AW  read-port addresses.
- `wr_en`  out  NREG  one-hot `in_en` drive to the register cells.
- `wr_data`  out  DW  write data to the register cells.
- `out_en1`, `out_en2`  out  NREG  one-hot read enables for ports 1 and 2.
- `rd_zero1`, `rd_zero2`  out  1  read address is 0; the datapath substitutes 0 for the floating bus.
- `fwd1`, `fwd2`  out  1  forward `fwd_data` instead of the bus.
- `fwd_data`  out  DW  forwarded write data.
- `busy`  out  1  a write is pending in the pipeline stage.

## Operation
- State: `rr_ptr` [$clog2(NREQ)], `pend`, `addr_q` [AW], `data_q` [DW].
- Arbitration is combinational:
  - Search order is `rr_ptr`, `rr_ptr+1`, … mod NREQ.
  - The first requester with `req_valid` set gets its `req_ready` bit set.
  - At most one `req_ready` bit is high per cycle.
  - The port accepts one write every cycle; back-pressure comes only from losing arbitration.
- On a clock edge with grant to requester g:
  - `rr_ptr <= (g+1) mod NREQ`.
  - `addr_q <= req_addr[g]`, `data_q <= req_data[g]`.
  - `pend <= (req_addr[g] != 0)`. A write to register 0 is accepted and then dropped.
- On a clock edge with no grant: `pend <= 0`; `rr_ptr`, `addr_q` and `data_q` hold.
- `wr_en = pend ? (1 << addr_q) : 0`; `wr_data = data_q`; `busy = pend`.
- Read decode:
  - `out_en1 = (rd_addr1 == 0) ? 0 : (1 << rd_addr1)`; `rd_zero1 = (rd_addr1 == 0)`.
  - Port 2 is decoded identically from `rd_addr2`.
- Requesters hold `req_valid`, `req_addr` and `req_data` stable until ready. Dropping valid before ready is legal and withdraws the request.
- Simultaneous requests: exactly one is granted, in round-robin order. With all NREQ requesters continuously valid, each is granted once every NREQ cycles.
- Reset (`clr` high, asynchronous):
  - `rr_ptr = 0`, `pend = 0`, `addr_q = 0`, `data_q = 0`.
  - `req_ready` is forced to 0 while `clr` is high.
  - Hence `wr_en = 0`, `wr_data = 0`, `busy = 0`, `fwd1 = fwd2 = 0`, `fwd_data = 0`.
  - A write pending when `clr` rises is discarded.

## Timing
- Request accepted at edge N (valid&ready sampled) → `wr_en` asserted during cycle N..N+1 → register cell captures at edge N+1. Grant-to-written latency is 2 edges.
- `req_ready`, `out_en*`, `rd_zero*` and `fwd*` are combinational from the current inputs and state; no registered read path.
- Read of register r in the cycle where `pend && addr_q == r`: the cell still drives the old value, because the write lands at the next edge.
- Back-to-back grants to the same address: the second write reaches the cell one cycle after the first.

## Configuration
- `REGFILE_ARB_BYPASS_EN` defined:
  - `fwd1 = pend && (rd_addr1 == addr_q)`; `fwd2` likewise from `rd_addr2`.
  - `fwd_data = data_q`.
  - The datapath thereby sees the new value in the same cycle the write is pending.
- Not defined:
  - `fwd1 = fwd2 = 0` and `fwd_data = 0`.
  - A read in the pending cycle returns the old value; the consumer schedules around the 1-cycle window.
- Arbitration and decode behaviour are identical in both builds.

## Test plan
- Reset: assert `clr` mid-cycle with a write pending → `wr_en` = 0, `busy` = 0 and `req_ready` = 0 immediately. After release, requester 0 valid → `req_ready` = 4'b0001 with `rr_ptr` = 0.
- Single write: req1 valid, addr 7, data 0xDEADBEEF at edge N → `wr_en` = 1<<7 and `wr_data` = 0xDEADBEEF during cycle N+1. `wr_en` = 0 in the following cycle if idle.
- Round-robin: all 4 valid continuously for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. Req2 alone valid after grant to 3 → granted immediately.
- Register 0: write addr 0 data 0x55 → `req_ready` pulses and `wr_en` stays 0. `rd_addr1` = 0 → `out_en1` = 0 and `rd_zero1` = 1.
- Read decode: `rd_addr1` = 31, `rd_addr2` = 1 → `out_en1` = 1<<31, `out_en2` = 1<<1, `rd_zero*` = 0.
- Bypass: write addr 5 data 0x1234, `rd_addr2` = 5 in the pending cycle:
  - With `REGFILE_ARB_BYPASS_EN`: `fwd2` = 1 and `fwd_data` = 0x1234; `fwd1` = 0 with `rd_addr1` = 6.
  - Without it: `fwd2` = 0.
